bringup_vram_march: RTL and testbench

//  Parametrised VRAM bring-up tester: runs a 4-phase march (W0 up, R0 up, W1 down, R1 down) over both VRAM

---
 rtl/bringup_vram_march.sv | 243 ++++++++++++++++++++++++
 tb/tb_bringup_vram_march.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bringup_vram_march.sv
`default_nettype none
// ============================================================================
//  Module   : bringup_vram_march
//  Purpose  : Four-phase march test over both VRAM byte lanes with programmable
//             access timing; counts and locates read mismatches.
//  Revision : 1.0  initial release
// ============================================================================
module bringup_vram_march #(
  parameter int ADDR_BITS     = 15,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int TURN_CYCLES   = 4,
  parameter int PATTERN       = 0,
  parameter int ERR_BITS      = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_BITS-1:0] err_count,
  output logic [14:0]         fail_addr,
  output logic [1:0]          fail_phase,
  output logic [1:0]          fail_lane,
  output logic                lvl_va_dir,
  output logic                lvl_vd_dir,
  output logic                vrd_n,
  output logic                vawr_n,
  output logic                vbwr_n,
  output logic                va14,
  output logic [13:0]         vaa,
  output logic [13:0]         vab,
  output logic [7:0]          vda_o,
  output logic [7:0]          vdb_o,
  input  logic [7:0]          vda_i,
  input  logic [7:0]          vdb_i,
  output logic                led7,
  output logic                led8
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } state_t;

  localparam int                  c_CNT_W       = 16;
  localparam logic [c_CNT_W-1:0]  c_SETUP_LAST  = c_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_STROBE_LAST = c_CNT_W'(STROBE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_HOLD_LAST   = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_TURN_LAST   = c_CNT_W'(TURN_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] c_ADDR_LAST  = '1;

  state_t               r_state, w_state_next;
  logic [1:0]           r_phase, w_phase_next;
  logic [ADDR_BITS-1:0] r_addr, w_addr_next, w_addr_step;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
  logic                 w_start_ok, w_phase_end, w_to_idle;

  // Phase bit 1 selects inverted data and the downward walk.
  function automatic logic [7:0] pat_data(input logic [ADDR_BITS-1:0] a, input logic inv);
    logic [7:0] d;
    if (PATTERN == 0) d = 8'(a);
    else              d = a[0] ? 8'hAA : 8'h55;
    return inv ? ~d : d;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_addr_next  = r_addr;
    w_cnt_next   = r_cnt + 1'b1;
    w_to_idle    = 1'b0;
    w_start_ok   = (r_state == ST_IDLE) && start;
    w_phase_end  = r_phase[1] ? (r_addr == '0) : (r_addr == c_ADDR_LAST);
    w_addr_step  = r_phase[1] ? (r_addr - 1'b1) : (r_addr + 1'b1);
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          w_state_next = ST_SETUP;
          w_phase_next = 2'd0;
          w_addr_next  = '0;
        end
      end
      ST_SETUP: if (r_cnt == c_SETUP_LAST) begin
        w_state_next = ST_STROBE;
        w_cnt_next   = '0;
      end
      ST_STROBE: if (r_cnt == c_STROBE_LAST) begin
        w_state_next = ST_HOLD;
        w_cnt_next   = '0;
      end
      ST_HOLD: if (r_cnt == c_HOLD_LAST) begin
        w_cnt_next = '0;
        if (!w_phase_end) begin
          w_state_next = ST_SETUP;
          w_addr_next  = w_addr_step;
        end else if (r_phase == 2'd3) begin
          w_state_next = ST_IDLE;
          w_to_idle    = 1'b1;
        end else begin
          // Write phases wrap into the start of the next read; reads restart where they ended.
          w_state_next = ST_TURN;
          if (!r_phase[0]) w_addr_next = w_addr_step;
        end
      end
      ST_TURN: if (r_cnt == c_TURN_LAST) begin
        w_state_next = ST_SETUP;
        w_phase_next = r_phase + 2'd1;
        w_cnt_next   = '0;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_addr  <= w_addr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Pin registers are loaded from next-state values so they line up with the state.
  logic        r_vrd_n, r_vwr_n, r_vd_dir;
  logic [14:0] r_pin_addr;
  logic [7:0]  r_pin_data;
  logic        w_acc_next, w_wr_next;

  assign w_acc_next = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                      (w_state_next == ST_HOLD);
  assign w_wr_next  = !w_phase_next[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vrd_n    <= 1'b1;
      r_vwr_n    <= 1'b1;
      r_vd_dir   <= 1'b0;
      r_pin_addr <= '0;
      r_pin_data <= '0;
    end else begin
      r_vrd_n    <= !((w_state_next == ST_STROBE) && !w_wr_next);
      r_vwr_n    <= !((w_state_next == ST_STROBE) && w_wr_next);
      r_vd_dir   <= w_acc_next && w_wr_next;
      r_pin_addr <= 15'(w_addr_next);
      r_pin_data <= pat_data(w_addr_next, w_phase_next[1]);
    end
  end

  logic                r_cmp_vld, r_busy, r_done, r_pass;
  logic [7:0]          r_rd_a, r_rd_b, r_exp;
  logic [14:0]         r_cmp_addr, r_fail_addr;
  logic [1:0]          r_cmp_phase, r_fail_phase, r_fail_lane;
  logic [ERR_BITS-1:0] r_err_count;
  logic [1:0]          w_mis;
  logic                w_err_hit;

  assign w_mis     = {r_rd_b != r_exp, r_rd_a != r_exp};
  assign w_err_hit = r_cmp_vld && (w_mis != 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp_vld    <= 1'b0;
      r_rd_a       <= '0;
      r_rd_b       <= '0;
      r_exp        <= '0;
      r_cmp_addr   <= '0;
      r_cmp_phase  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_addr  <= '0;
      r_fail_phase <= '0;
      r_fail_lane  <= '0;
    end else begin
      r_cmp_vld <= (r_state == ST_STROBE) && (r_cnt == c_STROBE_LAST) && r_phase[0];
      if ((r_state == ST_STROBE) && (r_cnt == c_STROBE_LAST)) begin
        r_rd_a      <= vda_i;
        r_rd_b      <= vdb_i;
        r_exp       <= pat_data(r_addr, r_phase[1]);
        r_cmp_addr  <= 15'(r_addr);
        r_cmp_phase <= r_phase;
      end
      r_busy <= (w_state_next != ST_IDLE);
      if (w_start_ok) begin
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_err_count  <= '0;
        r_fail_addr  <= '0;
        r_fail_phase <= '0;
        r_fail_lane  <= '0;
      end else begin
        if (w_err_hit) begin
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
          if (r_err_count == '0) begin
            r_fail_addr  <= r_cmp_addr;
            r_fail_phase <= r_cmp_phase;
            r_fail_lane  <= w_mis;
          end
        end
        // The last compare can land on the same edge as the return to idle.
        if (w_to_idle) begin
          r_done <= 1'b1;
          r_pass <= !w_err_hit && (r_err_count == '0);
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign fail_addr  = r_fail_addr;
  assign fail_phase = r_fail_phase;
  assign fail_lane  = r_fail_lane;
  assign lvl_va_dir = 1'b1;
  assign lvl_vd_dir = r_vd_dir;
  assign vrd_n      = r_vrd_n;
  assign vawr_n     = r_vwr_n;
  assign vbwr_n     = r_vwr_n;
  assign va14       = r_pin_addr[14];
  assign vaa        = r_pin_addr[13:0];
  assign vab        = r_pin_addr[13:0];
  assign vda_o      = r_pin_data;
  assign vdb_o      = r_pin_data;
  assign led7       = r_busy;
  assign led8       = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_bringup_vram_march.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bringup_vram_march
//  Purpose  : Bench for bringup_vram_march with a 16-word two-lane RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bringup_vram_march;

  localparam int c_N = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clock = ~clock;

  logic        busy, done, pass, lvl_va_dir, lvl_vd_dir, vrd_n, vawr_n, vbwr_n, va14, led7, led8;
  logic [15:0] err_count;
  logic [14:0] fail_addr;
  logic [1:0]  fail_phase, fail_lane;
  logic [13:0] vaa, vab;
  logic [7:0]  vda_o, vdb_o, vda_i, vdb_i;

  logic        busy2, done2, pass2, lvl_va_dir2, lvl_vd_dir2, vrd_n2, vawr_n2, vbwr_n2, va14_2, led7_2, led8_2;
  logic [1:0]  err_count2;
  logic [14:0] fail_addr2;
  logic [1:0]  fail_phase2, fail_lane2;
  logic [13:0] vaa2, vab2;
  logic [7:0]  vda_o2, vdb_o2;

  bringup_vram_march #(.ADDR_BITS(4), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1),
                       .TURN_CYCLES(2), .PATTERN(0), .ERR_BITS(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_phase(fail_phase), .fail_lane(fail_lane),
    .lvl_va_dir(lvl_va_dir), .lvl_vd_dir(lvl_vd_dir), .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n),
    .va14(va14), .vaa(vaa), .vab(vab), .vda_o(vda_o), .vdb_o(vdb_o), .vda_i(vda_i), .vdb_i(vdb_i),
    .led7(led7), .led8(led8));

  // Second instance: narrow error counter against a RAM that always reads zero.
  bringup_vram_march #(.ADDR_BITS(4), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1),
                       .TURN_CYCLES(2), .PATTERN(0), .ERR_BITS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_addr(fail_addr2), .fail_phase(fail_phase2), .fail_lane(fail_lane2),
    .lvl_va_dir(lvl_va_dir2), .lvl_vd_dir(lvl_vd_dir2), .vrd_n(vrd_n2), .vawr_n(vawr_n2), .vbwr_n(vbwr_n2),
    .va14(va14_2), .vaa(vaa2), .vab(vab2), .vda_o(vda_o2), .vdb_o(vdb_o2), .vda_i(8'h00), .vdb_i(8'h00),
    .led7(led7_2), .led8(led8_2));

  // RAM model. mode 0: ideal, 1: lane B bit 3 stuck-0 at word 5, 2: address bit 2 ignored.
  int         mode = 0;
  logic [7:0] mem_a [c_N];
  logic [7:0] mem_b [c_N];

  function automatic logic [3:0] ram_idx(input logic [3:0] a);
    return (mode == 2) ? (a & 4'b1011) : a;
  endfunction

  always @(posedge clock) begin
    if (!vawr_n) mem_a[ram_idx(vaa[3:0])] <= vda_o;
    if (!vbwr_n) mem_b[ram_idx(vab[3:0])] <= vdb_o;
  end

  always_comb begin
    vda_i = mem_a[ram_idx(vaa[3:0])];
    vdb_i = mem_b[ram_idx(vab[3:0])];
    if (mode == 1 && vab[3:0] == 4'd5) vdb_i = vdb_i & 8'hF7;
  end

  // Expected access order: {is_write, addr[14:0], write data}.
  logic [23:0] acc_exp [4*c_N];

  // Waveform monitor, sampled on the falling edge.
  logic        mon_clr = 1'b1;
  logic [22:0] prev_ad, pulse_ad;
  logic        prev_low, prev_lvl;
  int          low_len, gap_len, pulse_cnt, viol, ng2, ng4, busy_len;

  always @(negedge clock) begin
    logic        s_low;
    logic [22:0] ad;
    logic [23:0] ex;
    s_low = !vrd_n || !vawr_n || !vbwr_n;
    ad    = {va14, vaa, vda_o};
    if (mon_clr) begin
      low_len = 0; gap_len = 0; pulse_cnt = 0; viol = 0; ng2 = 0; ng4 = 0; busy_len = 0;
      prev_low = 1'b0; prev_ad = ad; pulse_ad = ad; prev_lvl = lvl_vd_dir;
    end else begin
      if (busy) busy_len++;
      if (vaa !== vab || vda_o !== vdb_o || vawr_n !== vbwr_n || lvl_va_dir !== 1'b1) viol++;
      if (s_low) begin
        if (!vrd_n && !vawr_n) viol++;
        if (lvl_vd_dir !== !vawr_n) viol++;
        if (lvl_vd_dir !== prev_lvl) viol++;
        if (!prev_low) begin
          if (pulse_cnt > 0) begin
            if (gap_len == 2) ng2++;
            else if (gap_len == 4) ng4++;
            else viol++;
          end
          if (ad !== prev_ad) viol++;
          if (pulse_cnt < 4*c_N) begin
            ex = acc_exp[pulse_cnt];
            if (ex[23] !== !vawr_n || ex[22:8] !== {va14, vaa} || (ex[23] && ex[7:0] !== vda_o)) viol++;
          end else viol++;
          pulse_cnt++;
          pulse_ad = ad;
          low_len  = 1;
        end else begin
          low_len++;
          if (ad !== pulse_ad) viol++;
        end
      end else if (prev_low) begin
        if (low_len != 2) viol++;
        if (ad !== pulse_ad) viol++;
        gap_len = 1;
      end else begin
        gap_len++;
      end
      prev_low = s_low;
      prev_ad  = ad;
      prev_lvl = lvl_vd_dir;
    end
  end

  typedef struct {
    int mode;
    bit restart;
    int err;
    int faddr;
    int fphase;
    int flane;
    bit pass;
  } vec_t;

  vec_t vecs [4];
  vec_t q_exp [$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_test(input vec_t v);
    vec_t e;
    bit   seen;
    mode = v.mode;
    mon_clr = 1'b1;
    @(negedge clock); #1;
    mon_clr = 1'b0;
    start = 1'b1;
    q_exp.push_back(v);
    @(negedge clock); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clear", done, 0);
    chk("start_err_clear", err_count, 0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      start = (v.restart && cyc == 100);
      @(negedge clock); #1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    e = q_exp.pop_front();
    chk("err_count", err_count, e.err);
    chk("fail_addr", fail_addr, e.faddr);
    chk("fail_phase", fail_phase, e.fphase);
    chk("fail_lane", fail_lane, e.flane);
    chk("pass", pass, e.pass);
    chk("led8", led8, e.pass);
    chk("led7_idle", led7, 0);
    chk("busy_len", busy_len, 4*c_N*4 + 3*2);
    chk("pulse_count", pulse_cnt, 4*c_N);
    chk("turn_gaps", ng4, 3);
    chk("access_gaps", ng2, 4*c_N - 4);
    chk("waveform_violations", viol, 0);
  endtask

  initial begin
    bit   seen;
    int   a;
    logic [7:0] d;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < c_N; k++) begin
        a = (p < 2) ? k : (c_N - 1 - k);
        d = 8'(a);
        if (p >= 2) d = ~d;
        acc_exp[p*c_N + k] = {(p % 2 == 0), 15'(a), d};
      end
    end
    vecs[0] = '{mode: 0, restart: 1'b0, err: 0,  faddr: 0, fphase: 0, flane: 0, pass: 1'b1};
    vecs[1] = '{mode: 1, restart: 1'b0, err: 1,  faddr: 5, fphase: 3, flane: 2, pass: 1'b0};
    vecs[2] = '{mode: 2, restart: 1'b0, err: 16, faddr: 0, fphase: 1, flane: 3, pass: 1'b0};
    vecs[3] = '{mode: 0, restart: 1'b1, err: 0,  faddr: 0, fphase: 0, flane: 0, pass: 1'b1};

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #1;
    chk("rst_vrd_n", vrd_n, 1);
    chk("rst_vawr_n", vawr_n, 1);
    chk("rst_vbwr_n", vbwr_n, 1);
    chk("rst_lvl_vd_dir", lvl_vd_dir, 0);
    chk("rst_lvl_va_dir", lvl_va_dir, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_addr", {va14, vaa}, 0);
    chk("rst_data", vda_o, 0);
    chk("rst_fail_addr", fail_addr, 0);

    start2 = 1'b1;
    @(negedge clock); #1;
    start2 = 1'b0;

    for (int i = 0; i < 4; i++) run_test(vecs[i]);

    chk("sat_done", done2, 1);
    chk("sat_err_count", err_count2, 3);
    chk("sat_pass", pass2, 0);
    chk("sat_fail_addr", fail_addr2, 1);
    chk("sat_fail_phase", fail_phase2, 1);
    chk("sat_fail_lane", fail_lane2, 3);

    // Asynchronous reset in the middle of a W1 strobe.
    mode = 0;
    mon_clr = 1'b1;
    @(negedge clock); #1;
    mon_clr = 1'b0;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clock); #1;
      if (pulse_cnt >= 2*c_N + 2 && !vawr_n) seen = 1'b1;
    end
    chk("w1_strobe_reached", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_vrd_n", vrd_n, 1);
    chk("arst_vawr_n", vawr_n, 1);
    chk("arst_vbwr_n", vbwr_n, 1);
    chk("arst_lvl_vd_dir", lvl_vd_dir, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_led7", led7, 0);
    @(negedge clock); #1;
    reset_n = 1'b1;
    run_test(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
